mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-low; ports: iClk, iRstN.
REQ-002 The block SHALL have these ports:
- iClk  in  1  rising-edge clock
- iRstN  in  1  synchronous active-low reset
- iStart  in  1  operation request, sampled on each edge
- iOp  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 reserved
- iA  in  32  rs operand, the multiplicand or dividend
- iB  in  32  rt operand, the multiplier or divisor
- iFlush  in  1  abort the in-flight operation
- oHi  out  32  HI register
- oLo  out  32  LO register
- oBusy  out  1  multi-cycle operation in progress; the pipeline stalls on HI/LO readers
- oDone  out  1  one-cycle pulse; HI/LO have just been updated by MULT, MULTU, DIV or DIVU

Function
REQ-003 The state machine SHALL have the states IDLE, MUL, DIV and FIX.
REQ-004 In IDLE, on an edge with iStart=1 and iFlush=0, the block SHALL accept the operation and latch iOp, iA and iB.
- MULT/MULTU go to MUL.
- DIV/DIVU go to DIV.
- The 6-bit iteration counter is cleared to 0.
REQ-005 MTHI and MTLO SHALL write iA into HI or LO on the accept edge, stay in IDLE, leave oBusy=0 and not pulse oDone.
REQ-006 Reserved iOp values SHALL be ignored: no state change and no register write.
REQ-007 oBusy SHALL be 1 exactly while the state is MUL, DIV or FIX.
REQ-008 Any iStart while oBusy=1 SHALL be ignored, and the in-flight operation SHALL be unaffected.
REQ-009 MUL SHALL run radix-2 shift-add: one partial product per edge, 32 edges, with the counter going 0 to 31. After the 32nd edge the state SHALL be FIX.
REQ-010 DIV SHALL run restoring division on the operand magnitudes: one quotient bit per edge, 32 edges. After the 32nd edge the state SHALL be FIX.
REQ-011 The FIX edge SHALL:
- apply the sign corrections;
- write HI and LO;
- set oDone=1 for the following cycle only;
- return to IDLE.
REQ-012 Latency SHALL be fixed: the accept edge is E0 and HI/LO update at E33. oBusy is 1 from E0 to E33, and oDone is high for exactly the cycle after E33.
REQ-013 The earliest next accept SHALL be E34. In the oDone cycle, oBusy=0 and a new iStart SHALL be accepted.
REQ-014 MULT SHALL form the signed 64-bit product of iA and iB, and MULTU the unsigned product; HI is bits 63:32 and LO is bits 31:0.
REQ-015 DIV/DIVU results SHALL be LO=quotient and HI=remainder.
- For DIV, the quotient is truncated toward zero, the quotient sign is sign(iA) XOR sign(iB), and the remainder takes the sign of iA.
REQ-016 For DIV with iA=0x80000000 and iB=0xFFFFFFFF, the result SHALL be LO=0x80000000, HI=0x00000000, with no exception.
REQ-017 Divide by zero (iB=0) SHALL still take the full 33-edge latency and produce LO=0xFFFFFFFF, HI=iA for both DIV and DIVU.
REQ-018 iFlush=1 on any edge SHALL force IDLE, leave HI/LO unchanged and suppress oDone.
- If iFlush and iStart are both 1 on the same edge, flush wins and the start is discarded; this includes MTHI/MTLO.
REQ-019 HI/LO SHALL change only on an MTHI/MTLO accept edge, a FIX edge or reset.

Reset
REQ-020 On an edge with iRstN=0 the block SHALL set state=IDLE, counter=0, oHi=0, oLo=0, oBusy=0 and oDone=0.
REQ-021 Reset SHALL have priority over iFlush and iStart, and reset mid-operation SHALL discard that operation without a partial HI/LO write.

Configuration
REQ-022 Macro MDU_DIV_EN SHALL control the divider datapath.
- Defined: DIV/DIVU behave per REQ-010 and REQ-015 to REQ-017.
- Undefined: the divider is not built, and DIV/DIVU are treated as reserved per REQ-006; MULT, MULTU, MTHI and MTLO are unchanged.

Verification
REQ-023 The bench SHALL cover these directed scenarios (DIV scenarios with MDU_DIV_EN defined):
- Reset, then MULTU with iA=0xFFFFFFFF, iB=0x00000002 -> at E33 HI=0x00000001, LO=0xFFFFFFFE; oDone pulses once; oBusy is high for E0 to E33.
- MULT with iA=0xFFFFFFFD (-3), iB=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV with iA=0xFFFFFFF9 (-7), iB=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV with 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU with iA=0x12345678, iB=0 -> at E33 LO=0xFFFFFFFF, HI=0x12345678.
- Start MULTU 5x5, assert iFlush at E10 -> IDLE, HI/LO keep prior values, no oDone. Then iStart with iFlush together -> ignored.
- MTHI iA=0xA5A5A5A5 -> oHi updates the next cycle with no oBusy. iStart MULT at E5 of a DIV -> ignored, and the DIV result is correct. Build without MDU_DIV_EN, issue DIV -> no busy and HI/LO unchanged.

Source files
------------

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide unit: fixed 33-edge shift-add multiply and restoring divide.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU are ignored like reserved ops.
module mdu_ctrl (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStart,
    input  logic [2:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iFlush,
    output logic [31:0] oHi,
    output logic [31:0] oLo,
    output logic        oBusy,
    output logic        oDone
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } stateT;

    stateT       state;
    logic [5:0]  cnt;
    logic [31:0] opnd;      // multiplicand magnitude or divisor magnitude
    logic [63:0] acc;       // {partial product} or {remainder, quotient}
    logic        negLo;     // negate whole product, or the quotient
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        busyReg;
    logic        doneReg;
`ifdef MDU_DIV_EN
    logic        isDiv;
    logic        negHi;
    logic        divZero;
`endif

    logic        signedOp;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] mulSum;
    logic [63:0] mulNext;
    logic [63:0] mulRes;
    logic [31:0] fixHi;
    logic [31:0] fixLo;
`ifdef MDU_DIV_EN
    logic [32:0] divShift;
    logic        divGe;
    logic [31:0] divRem;
    logic [63:0] divNext;
`endif

    always_comb begin
        signedOp = ~iOp[0];
        magA     = (signedOp && iA[31]) ? (32'd0 - iA) : iA;
        magB     = (signedOp && iB[31]) ? (32'd0 - iB) : iB;

        // acc[31:0] starts as the multiplier and shifts out LSB-first
        mulSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mulNext  = {mulSum, acc[31:1]};
        mulRes   = negLo ? (64'd0 - acc) : acc;

        fixHi    = mulRes[63:32];
        fixLo    = mulRes[31:0];
`ifdef MDU_DIV_EN
        divShift = acc[63:31];
        divGe    = (divShift >= {1'b0, opnd});
        divRem   = divGe ? 32'(divShift - {1'b0, opnd}) : divShift[31:0];
        divNext  = {divRem, acc[30:0], divGe};

        if (isDiv) begin
            // remainder magnitude with dividend sign already reproduces iA when dividing by zero
            fixHi = negHi ? (32'd0 - acc[63:32]) : acc[63:32];
            fixLo = divZero ? 32'hFFFF_FFFF
                            : (negLo ? (32'd0 - acc[31:0]) : acc[31:0]);
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            opnd    <= 32'd0;
            acc     <= 64'd0;
            negLo   <= 1'b0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
`ifdef MDU_DIV_EN
            isDiv   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
`endif
        end else begin
            doneReg <= 1'b0;
            if (iFlush) begin
                state   <= IDLE;
                cnt     <= 6'd0;
                busyReg <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iStart) begin
                            case (iOp)
                                OP_MULT, OP_MULTU: begin
                                    state   <= MUL;
                                    busyReg <= 1'b1;
                                    cnt     <= 6'd0;
                                    opnd    <= magA;
                                    acc     <= {32'd0, magB};
                                    negLo   <= signedOp & (iA[31] ^ iB[31]);
`ifdef MDU_DIV_EN
                                    isDiv   <= 1'b0;
`endif
                                end
`ifdef MDU_DIV_EN
                                OP_DIV, OP_DIVU: begin
                                    state   <= DIV;
                                    busyReg <= 1'b1;
                                    cnt     <= 6'd0;
                                    opnd    <= magB;
                                    acc     <= {32'd0, magA};
                                    negLo   <= signedOp & (iA[31] ^ iB[31]);
                                    negHi   <= signedOp & iA[31];
                                    divZero <= (iB == 32'd0);
                                    isDiv   <= 1'b1;
                                end
`endif
                                OP_MTHI: hiReg <= iA;
                                OP_MTLO: loReg <= iA;
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        acc <= mulNext;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= FIX;
                        end
                    end
                    DIV: begin
`ifdef MDU_DIV_EN
                        acc <= divNext;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= FIX;
                        end
`else
                        state   <= IDLE;
                        busyReg <= 1'b0;
`endif
                    end
                    FIX: begin
                        hiReg   <= fixHi;
                        loReg   <= fixLo;
                        doneReg <= 1'b1;
                        busyReg <= 1'b0;
                        cnt     <= 6'd0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign oHi   = hiReg;
    assign oLo   = loReg;
    assign oBusy = busyReg;
    assign oDone = doneReg;

endmodule
